// File: rtl/semafor_monitor.sv
// Passive checker for the pedestrian-light LED bus: decodes the LED pattern into a
// phase, checks sequence and minimum durations, and watches pedestrian request service.
module semafor_monitor #(
    parameter int unsigned MIN_VERDE  = 48000000,
    parameter int unsigned MIN_GALBEN = 36000000,
    parameter int unsigned MIN_ROSU   = 72000000,
    parameter int unsigned MIN_DELAY  = 96000000,
    parameter int unsigned MAX_WAIT   = 150000000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  led,
    input  logic        btn,
    input  logic        clr_err,
    output logic [2:0]  phase,
    output logic        tracking,
    output logic        err_illegal,
    output logic        err_seq,
    output logic        err_short,
    output logic        err_timeout,
    output logic        req_pending,
    output logic [15:0] cycle_count
);

    localparam logic [2:0] PH_VERDE   = 3'd0;
    localparam logic [2:0] PH_GALBEN  = 3'd1;
    localparam logic [2:0] PH_ROSU    = 3'd2;
    localparam logic [2:0] PH_DELAY   = 3'd3;
    localparam logic [2:0] PH_UNKNOWN = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] MIN_V_C     = CNT_W'(MIN_VERDE);
    localparam logic [CNT_W-1:0] MIN_G_C     = CNT_W'(MIN_GALBEN);
    localparam logic [CNT_W-1:0] MIN_R_C     = CNT_W'(MIN_ROSU);
    localparam logic [CNT_W-1:0] MIN_D_C     = CNT_W'(MIN_DELAY);
    localparam logic [CNT_W-1:0] WAIT_LAST_C = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {SYNC, TRACK} state_t;

    state_t           state, state_d;
    logic [2:0]       dec;
    logic [CNT_W-1:0] dur;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] min_cur;
    logic             change, legal;
    logic             set_illegal, set_seq, set_short, set_timeout;
    logic             cnt_inc, req_set, req_clr;

    always_comb begin
        case (led)
            8'b11011110: dec = PH_VERDE;
            8'b11101110: dec = PH_GALBEN;
            8'b11110101: dec = PH_ROSU;
            8'b01011110: dec = PH_DELAY;
            default:     dec = PH_UNKNOWN;
        endcase
    end

    assign change   = (dec != phase);
    assign tracking = (state == TRACK);
    assign legal    = (phase == PH_VERDE  && dec == PH_GALBEN) ||
                      (phase == PH_GALBEN && dec == PH_ROSU)   ||
                      (phase == PH_ROSU   && dec == PH_DELAY)  ||
                      (phase == PH_DELAY  && dec == PH_VERDE);

    always_comb begin
        case (phase)
            PH_VERDE:  min_cur = MIN_V_C;
            PH_GALBEN: min_cur = MIN_G_C;
            PH_ROSU:   min_cur = MIN_R_C;
            PH_DELAY:  min_cur = MIN_D_C;
            default:   min_cur = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SYNC;
        else        state <= state_d;
    end

    // The registered phase is the "old" phase, so every check compares it against dec.
    always_comb begin
        state_d     = state;
        set_illegal = 1'b0;
        set_seq     = 1'b0;
        set_short   = 1'b0;
        set_timeout = 1'b0;
        cnt_inc     = 1'b0;
        req_set     = 1'b0;
        req_clr     = 1'b0;
        case (state)
            SYNC: begin
                if (dec == PH_VERDE) state_d = TRACK;
            end
            TRACK: begin
                if (change) begin
                    if (dec == PH_UNKNOWN) begin
                        set_illegal = 1'b1;
                        req_clr     = 1'b1;
                        state_d     = SYNC;
                    end else if (!legal) begin
                        set_seq = 1'b1;
                    end else begin
                        if (dur < min_cur)     set_short = 1'b1;
                        if (phase == PH_DELAY) cnt_inc   = 1'b1;
                    end
                    if (dec == PH_GALBEN) req_clr = 1'b1;
                end
                if (!req_pending && btn && (phase == PH_VERDE || phase == PH_DELAY))
                    req_set = 1'b1;
                if (req_pending && !req_clr && wait_cnt == WAIT_LAST_C)
                    set_timeout = 1'b1;
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_UNKNOWN;
            dur   <= '0;
        end else begin
            phase <= dec;
            if (change)              dur <= {{(CNT_W-1){1'b0}}, 1'b1};
            else if (dur != CNT_MAX) dur <= dur + 1'b1;
        end
    end

    // Clearing on GALBEN or SYNC entry takes priority over a same-cycle new request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_pending <= 1'b0;
            wait_cnt    <= '0;
        end else if (req_clr) begin
            req_pending <= 1'b0;
        end else if (req_set) begin
            req_pending <= 1'b1;
            wait_cnt    <= '0;
        end else if (req_pending && wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_illegal <= 1'b0;
            err_seq     <= 1'b0;
            err_short   <= 1'b0;
            err_timeout <= 1'b0;
            cycle_count <= 16'd0;
        end else begin
            err_illegal <= (err_illegal && !clr_err) || set_illegal;
            err_seq     <= (err_seq     && !clr_err) || set_seq;
            err_short   <= (err_short   && !clr_err) || set_short;
            err_timeout <= (err_timeout && !clr_err) || set_timeout;
            if (cnt_inc) cycle_count <= cycle_count + 16'd1;
        end
    end

endmodule
